// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the signals exchanged between the 5-stage pipeline datapath and
//   the hazard/sequencing controller.
//
//   Parameter:
//     ADDR_W  register-file address width
//
//   Pipeline -> controller (controller inputs):
//     id_read_addr_1/2        rs1/rs2 of the instruction in ID (0 = unused)
//     ex_read_addr_1/2        rs1/rs2 held in the ID/EX register
//     ex_reg_write_enable     ID/EX write enable
//     ex_reg_write_addr       ID/EX rd
//     ex_is_load              ID/EX instruction writes back memory data
//     mem_reg_write_enable    EX/MEM write enable
//     mem_reg_write_addr      EX/MEM rd
//     wb_reg_write_enable     MEM/WB write enable
//     wb_reg_write_addr       MEM/WB rd
//     mem_branch              EX/MEM holds a branch
//     mem_zero                EX/MEM ALU zero flag
//     mem_branch_direction    1 = taken on zero, 0 = taken on nonzero
//     dmem_busy               data memory not ready this cycle
//
//   Controller -> pipeline (controller outputs):
//     stall_flag              bubble at ID/EX, hold IF/ID and PC
//     branch_flag             flush IF/ID, ID/EX, EX/MEM; PC takes target
//     freeze                  hold every pipeline register and PC
//     pc_write_enable         PC update allowed
//     fwd_sel_1/2             00 regfile, 01 EX/MEM alu_out, 10 MEM/WB data
//     timeout_err             sticky memory-timeout error
//     state                   00 RUN, 01 WAIT, 10 ERR (debug)
//
//   Modports:
//     master  the pipeline datapath side
//     slave   the hazard controller side
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] id_read_addr_1;
  logic [ADDR_W-1:0] id_read_addr_2;
  logic [ADDR_W-1:0] ex_read_addr_1;
  logic [ADDR_W-1:0] ex_read_addr_2;
  logic              ex_reg_write_enable;
  logic [ADDR_W-1:0] ex_reg_write_addr;
  logic              ex_is_load;
  logic              mem_reg_write_enable;
  logic [ADDR_W-1:0] mem_reg_write_addr;
  logic              wb_reg_write_enable;
  logic [ADDR_W-1:0] wb_reg_write_addr;
  logic              mem_branch;
  logic              mem_zero;
  logic              mem_branch_direction;
  logic              dmem_busy;

  logic              stall_flag;
  logic              branch_flag;
  logic              freeze;
  logic              pc_write_enable;
  logic [1:0]        fwd_sel_1;
  logic [1:0]        fwd_sel_2;
  logic              timeout_err;
  logic [1:0]        state;

  modport master (
    output id_read_addr_1, id_read_addr_2,
    output ex_read_addr_1, ex_read_addr_2,
    output ex_reg_write_enable, ex_reg_write_addr, ex_is_load,
    output mem_reg_write_enable, mem_reg_write_addr,
    output wb_reg_write_enable, wb_reg_write_addr,
    output mem_branch, mem_zero, mem_branch_direction,
    output dmem_busy,
    input  stall_flag, branch_flag, freeze, pc_write_enable,
    input  fwd_sel_1, fwd_sel_2, timeout_err, state
  );

  modport slave (
    input  id_read_addr_1, id_read_addr_2,
    input  ex_read_addr_1, ex_read_addr_2,
    input  ex_reg_write_enable, ex_reg_write_addr, ex_is_load,
    input  mem_reg_write_enable, mem_reg_write_addr,
    input  wb_reg_write_enable, wb_reg_write_addr,
    input  mem_branch, mem_zero, mem_branch_direction,
    input  dmem_busy,
    output stall_flag, branch_flag, freeze, pc_write_enable,
    output fwd_sel_1, fwd_sel_2, timeout_err, state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central sequencer for the IF/ID/EX/MEM/WB pipeline registers. Detects
//   load-use hazards and taken branches, produces EX-stage forwarding
//   selects, freezes the pipeline while data memory is busy, and flags a
//   hung memory through a watchdog that counts consecutive busy cycles.
//
//   Parameters:
//     ADDR_W    register-file address width
//     MAX_WAIT  consecutive busy cycles tolerated in WAIT before ERR (1..255)
//     CNT_W     performance counter width (PIPE_CTRL_PERF_EN builds only)
//
//   Ports:
//     clk       pipeline clock
//     rst_n     synchronous active-low reset
//     bus       pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs)
//     stall_count, flush_count, wait_count
//               saturating counts of stall / branch / freeze cycles
//               (present only when PIPE_CTRL_PERF_EN is defined)
//
//   Configuration macro:
//     PIPE_CTRL_PERF_EN  adds the three performance counters.
//
//   All control outputs are combinational from the registered state and the
//   current inputs; only the FSM state, the wait counter and the sticky
//   timeout error are registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_count,
  output logic [CNT_W-1:0]        flush_count,
  output logic [CNT_W-1:0]        wait_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  // Just wide enough to hold MAX_WAIT.
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  logic taken;
  logic load_use;
  logic stall_c, branch_c, freeze_c, pc_we_c;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  assign taken = bus.mem_branch & (bus.mem_zero == bus.mem_branch_direction);

  assign load_use = bus.ex_is_load & bus.ex_reg_write_enable &
                    (bus.ex_reg_write_addr != '0) &
                    ((bus.ex_reg_write_addr == bus.id_read_addr_1) |
                     (bus.ex_reg_write_addr == bus.id_read_addr_2));

  // -------------------------------------------------------------------------
  // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 is hardwired
  // to zero so it is never forwarded.
  // -------------------------------------------------------------------------
  function automatic logic [1:0] fwd_select(
    input logic [ADDR_W-1:0] src,
    input logic              mem_we,
    input logic [ADDR_W-1:0] mem_rd,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_rd
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      return 2'b01;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  assign bus.fwd_sel_1 = fwd_select(bus.ex_read_addr_1,
                                    bus.mem_reg_write_enable, bus.mem_reg_write_addr,
                                    bus.wb_reg_write_enable, bus.wb_reg_write_addr);
  assign bus.fwd_sel_2 = fwd_select(bus.ex_read_addr_2,
                                    bus.mem_reg_write_enable, bus.mem_reg_write_addr,
                                    bus.wb_reg_write_enable, bus.wb_reg_write_addr);

  // -------------------------------------------------------------------------
  // FSM next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    stall_c    = 1'b0;
    branch_c   = 1'b0;
    freeze_c   = 1'b0;
    pc_we_c    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // Memory stall outranks everything: a frozen branch or load-use is
        // re-evaluated once the pipeline thaws.
        if (bus.dmem_busy) begin
          freeze_c   = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (taken) begin
          // The flush discards the instruction that would need the bubble.
          branch_c = 1'b1;
          pc_we_c  = 1'b1;
        end else if (load_use) begin
          stall_c = 1'b1;
        end else begin
          pc_we_c = 1'b1;
        end
      end

      ST_WAIT: begin
        freeze_c = 1'b1;
        if (!bus.dmem_busy) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end

      ST_ERR: begin
        // Only reset leaves ERR.
        freeze_c = 1'b1;
        err_d    = 1'b1;
      end

      default: begin
        // Unreachable encoding: recover to RUN.
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // While reset is held the pipeline must see no control activity.
    if (!rst_n) begin
      stall_c  = 1'b0;
      branch_c = 1'b0;
      freeze_c = 1'b0;
      pc_we_c  = 1'b0;
    end
  end

  assign bus.stall_flag      = stall_c;
  assign bus.branch_flag     = branch_c;
  assign bus.freeze          = freeze_c;
  assign bus.pc_write_enable = pc_we_c;
  assign bus.timeout_err     = err_q & rst_n;
  assign bus.state           = state_q;

  // -------------------------------------------------------------------------
  // State registers (synchronous reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters: count cycles with each flag asserted, saturating.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
      wait_count  <= '0;
    end else begin
      if (stall_c && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (branch_c && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      if (freeze_c && (wait_count != '1)) begin
        wait_count <= wait_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Scoreboard bench: each applied cycle pushes the reference model's
//   expected outputs into a queue; a monitor on the falling edge pops and
//   compares against the DUT. The model tracks the run of consecutive busy
//   cycles and a sticky error bit rather than the controller's FSM.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_count, flush_count, wait_count;
`endif

  pipeline_hazard_ctrl #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_count(stall_count),
    .flush_count(flush_count),
    .wait_count (wait_count)
`endif
  );

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct {
    logic  rst_n;
    addr_t id1, id2, ex1, ex2;
    logic  ex_we;  addr_t ex_rd; logic ex_load;
    logic  mem_we; addr_t mem_rd;
    logic  wb_we;  addr_t wb_rd;
    logic  br, zero, dir;
    logic  busy;
  } vec_t;

  typedef struct {
    logic       stall, branch, freeze, pc_we, terr;
    logic [1:0] f1, f2, st;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: length of the current run of busy cycles and sticky error.
  int   busy_run = 0;
  bit   err      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input addr_t src, input vec_t v);
    if (v.mem_we && v.mem_rd != 0 && v.mem_rd == src) return 2'b01;
    if (v.wb_we && v.wb_rd != 0 && v.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = '{rst_n: 1'b1, id1: '0, id2: '0, ex1: '0, ex2: '0,
          ex_we: 1'b0, ex_rd: '0, ex_load: 1'b0,
          mem_we: 1'b0, mem_rd: '0, wb_we: 1'b0, wb_rd: '0,
          br: 1'b0, zero: 1'b0, dir: 1'b0, busy: 1'b0};
    return v;
  endfunction

  function automatic exp_t predict(input vec_t v);
    exp_t e;
    bit   taken, lu;
    e.f1 = ref_fwd(v.ex1, v);
    e.f2 = ref_fwd(v.ex2, v);
    e.st = err ? 2'b10 : (busy_run == 0) ? 2'b00 : 2'b01;
    e.stall = 0; e.branch = 0; e.freeze = 0; e.pc_we = 0;
    e.terr  = v.rst_n & err;
    taken = v.br && (v.zero == v.dir);
    lu    = v.ex_load && v.ex_we && v.ex_rd != 0 && (v.ex_rd == v.id1 || v.ex_rd == v.id2);
    if (v.rst_n) begin
      if (e.st != 2'b00 || v.busy) e.freeze = 1;
      else if (taken) begin e.branch = 1; e.pc_we = 1; end
      else if (lu) e.stall = 1;
      else e.pc_we = 1;
    end
    return e;
  endfunction

  function automatic void advance(input vec_t v);
    if (!v.rst_n) begin
      busy_run = 0;
      err      = 0;
    end else if (!err) begin
      if (v.busy) begin
        busy_run++;
        if (busy_run > MAX_WAIT) err = 1;
      end else begin
        busy_run = 0;
      end
    end
  endfunction

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst_n                    = v.rst_n;
    bus.id_read_addr_1       = v.id1;
    bus.id_read_addr_2       = v.id2;
    bus.ex_read_addr_1       = v.ex1;
    bus.ex_read_addr_2       = v.ex2;
    bus.ex_reg_write_enable  = v.ex_we;
    bus.ex_reg_write_addr    = v.ex_rd;
    bus.ex_is_load           = v.ex_load;
    bus.mem_reg_write_enable = v.mem_we;
    bus.mem_reg_write_addr   = v.mem_rd;
    bus.wb_reg_write_enable  = v.wb_we;
    bus.wb_reg_write_addr    = v.wb_rd;
    bus.mem_branch           = v.br;
    bus.mem_zero             = v.zero;
    bus.mem_branch_direction = v.dir;
    bus.dmem_busy            = v.busy;
    exp_q.push_back(predict(v));
    advance(v);
  endtask

  // Monitor: compares one expected record per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_flag",      32'(bus.stall_flag),      32'(e.stall));
      check("branch_flag",     32'(bus.branch_flag),     32'(e.branch));
      check("freeze",          32'(bus.freeze),          32'(e.freeze));
      check("pc_write_enable", 32'(bus.pc_write_enable), 32'(e.pc_we));
      check("fwd_sel_1",       32'(bus.fwd_sel_1),       32'(e.f1));
      check("fwd_sel_2",       32'(bus.fwd_sel_2),       32'(e.f2));
      check("timeout_err",     32'(bus.timeout_err),     32'(e.terr));
      check("state",           32'(bus.state),           32'(e.st));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    int   waited;

    // Reset held for two cycles with memory busy, then released.
    v = idle(); v.rst_n = 0; v.busy = 1;
    step(v); step(v);
    v.rst_n = 1;
    step(v); step(v);
    v = idle(); step(v); step(v);

    // Load-use on rs2, then the same with rd = x0.
    v = idle(); v.ex_load = 1; v.ex_we = 1; v.ex_rd = 5; v.id2 = 5;
    step(v);
    v = idle(); step(v);
    v = idle(); v.ex_load = 1; v.ex_we = 1; v.ex_rd = 0; v.id2 = 0;
    step(v);

    // Taken branch beats an active load-use; then a not-taken branch.
    v = idle(); v.ex_load = 1; v.ex_we = 1; v.ex_rd = 5; v.id1 = 5;
    v.br = 1; v.zero = 1; v.dir = 1;
    step(v);
    v.zero = 0;
    step(v);

    // Forwarding priority and register 0.
    v = idle(); v.ex1 = 7; v.mem_we = 1; v.mem_rd = 7; v.wb_we = 1; v.wb_rd = 7;
    step(v);
    v.mem_we = 0;
    step(v);
    v = idle(); v.ex1 = 0; v.mem_we = 1; v.wb_we = 1;
    step(v);

    // Memory wait of three cycles, then release.
    v = idle(); v.busy = 1;
    repeat (3) step(v);
    v.busy = 0;
    step(v); step(v);

    // Watchdog: five busy cycles reach ERR, which survives busy dropping.
    v = idle(); v.busy = 1;
    repeat (6) step(v);
    v = idle(); v.br = 1; v.dir = 1; v.zero = 1;
    repeat (3) step(v);
    v = idle(); v.rst_n = 0;
    step(v);
    v = idle(); step(v);

    // Randomized traffic with small register addresses so hazards collide.
    for (int i = 0; i < 400; i++) begin
      v.rst_n   = ($urandom_range(0, 99) >= 3);
      v.id1     = addr_t'($urandom_range(0, 3));
      v.id2     = addr_t'($urandom_range(0, 3));
      v.ex1     = addr_t'($urandom_range(0, 3));
      v.ex2     = addr_t'($urandom_range(0, 3));
      v.ex_we   = 1'($urandom_range(0, 1));
      v.ex_rd   = addr_t'($urandom_range(0, 3));
      v.ex_load = 1'($urandom_range(0, 1));
      v.mem_we  = 1'($urandom_range(0, 1));
      v.mem_rd  = addr_t'($urandom_range(0, 3));
      v.wb_we   = 1'($urandom_range(0, 1));
      v.wb_rd   = addr_t'($urandom_range(0, 3));
      v.br      = ($urandom_range(0, 99) < 25);
      v.zero    = 1'($urandom_range(0, 1));
      v.dir     = 1'($urandom_range(0, 1));
      v.busy    = ($urandom_range(0, 99) < 35);
      step(v);
    end

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID/EX/MEM/WB).
- Detects load-use hazards and taken branches, and drives the stall and flush flags those registers consume.
- Generates EX-stage operand forwarding selects.
- Freezes the whole pipeline while data memory is busy; a watchdog counter flags a hung memory.

Parameters:
ADDR_W, 5, register-file address width
MAX_WAIT, 16, max consecutive dmem_busy cycles before a timeout error (1..255)
CNT_W, 32, perf counter width (used only with PIPE_CTRL_PERF_EN)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
id_read_addr_1  in  ADDR_W  rs1 of instruction in ID (0 = unused)
id_read_addr_2  in  ADDR_W  rs2 of instruction in ID (0 = unused)
ex_read_addr_1  in  ADDR_W  rs1 held in ID/EX register
ex_read_addr_2  in  ADDR_W  rs2 held in ID/EX register
ex_reg_write_enable  in  1  ID/EX write enable
ex_reg_write_addr  in  ADDR_W  ID/EX rd
ex_is_load  in  1  ID/EX instruction writes back memory data
mem_reg_write_enable  in  1  EX/MEM write enable
mem_reg_write_addr  in  ADDR_W  EX/MEM rd
wb_reg_write_enable  in  1  MEM/WB write enable
wb_reg_write_addr  in  ADDR_W  MEM/WB rd
mem_branch  in  1  EX/MEM holds a branch
mem_zero  in  1  EX/MEM ALU zero flag
mem_branch_direction  in  1  1 = taken on zero, 0 = taken on nonzero
dmem_busy  in  1  data memory not ready this cycle
stall_flag  out  1  insert bubble at ID/EX, hold IF/ID and PC
branch_flag  out  1  flush IF/ID, ID/EX, EX/MEM; PC takes branch target
freeze  out  1  hold every pipeline register and PC
pc_write_enable  out  1  PC update allowed
fwd_sel_1  out  2  ALU operand 1 source: 00 regfile, 01 EX/MEM alu_out, 10 MEM/WB write data
fwd_sel_2  out  2  same encoding, operand 2
timeout_err  out  1  sticky memory-timeout error
state  out  2  00 RUN, 01 WAIT, 10 ERR (debug)

Behaviour:
- Reset (rst_n=0 at posedge clk): state=RUN, wait counter=0, timeout_err=0. While in reset, all flag outputs are 0 and pc_write_enable=0. Reset mid-WAIT or in ERR returns to RUN.
- Definitions:
  - taken = mem_branch & (mem_zero == mem_branch_direction).
  - load_use = ex_is_load & ex_reg_write_enable & ex_reg_write_addr != 0 & (ex_reg_write_addr == id_read_addr_1 | ex_reg_write_addr == id_read_addr_2).
- All outputs are combinational from state and current inputs; only state, the counter and timeout_err are registered.
- RUN, priority dmem_busy > taken > load_use:
  - dmem_busy: freeze=1, stall_flag=0, branch_flag=0, pc_write_enable=0. Next state is WAIT and counter is set to 1.
  - taken: branch_flag=1, stall_flag=0 (the flush supersedes the load-use bubble), pc_write_enable=1. Stay in RUN.
  - load_use: stall_flag=1, pc_write_enable=0. Stay in RUN. The hazard clears by itself the next cycle, so the stall lasts exactly 1 cycle.
  - none of the above: all flags 0, pc_write_enable=1.
- WAIT:
  - freeze=1, other flags 0, pc_write_enable=0.
  - dmem_busy=0: return to RUN and clear the counter. Frozen branch or load_use conditions are then evaluated in RUN on the following cycle.
  - dmem_busy=1 with counter == MAX_WAIT: go to ERR and set timeout_err.
  - otherwise: counter increments. The counter saturates and never wraps.
- ERR: freeze=1, pc_write_enable=0, timeout_err=1. Exit only by reset.
- Forwarding (all states):
  - fwd_sel_n=01 if mem_reg_write_enable & mem_reg_write_addr != 0 & mem_reg_write_addr == ex_read_addr_n.
  - else fwd_sel_n=10 if the same condition holds for the wb_* signals.
  - else 00. EX/MEM always wins over MEM/WB; register 0 is never forwarded.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_count, flush_count, wait_count (each CNT_W wide).
  - Each increments by 1 on any cycle where stall_flag, branch_flag or freeze respectively is 1.
  - Each saturates at all-ones and clears on reset.
- Undefined: the ports and counter logic are absent; core behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with dmem_busy=1 -> state=00, freeze=0, timeout_err=0. Release -> next cycle freeze=1, state=01.
- Load-use: ex_is_load=1, ex_reg_write_enable=1, ex_reg_write_addr=5, id_read_addr_2=5 -> stall_flag=1 and pc_write_enable=0 for 1 cycle. The same case with ex_reg_write_addr=0 -> no stall.
- Branch beats load-use: mem_branch=1, mem_zero=1, mem_branch_direction=1, with a load_use case active -> branch_flag=1, stall_flag=0, pc_write_enable=1.
- Forwarding: ex_read_addr_1=7, mem rd=7 (we=1), wb rd=7 (we=1) -> fwd_sel_1=01. Set mem we=0 -> fwd_sel_1=10. Set ex_read_addr_1=0 with all rd=0 -> 00.
- Memory wait: dmem_busy=1 for 3 cycles -> freeze=1 for those 3 cycles, state=01 for the second and third. Drop dmem_busy -> state=00 next cycle, timeout_err=0.
- Timeout: MAX_WAIT=4, hold dmem_busy=1 -> state=10 and timeout_err=1 after the fifth busy cycle. These persist after dmem_busy drops and clear only on rst_n=0.
